// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: address range bound,
// owner encoding, full-word byte enable and the in-range helper.
package dm_arb_pkg;

    localparam int         DM_ADDR_HI = 13;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    // A byte address maps into the 2048-word array only when its upper bits are zero.
    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:DM_ADDR_HI] == '0;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle for dm_arbiter: CPU MEM-stage side, DMA requester side and
// the memory port. master = surrounding system, slave = the arbiter.
interface dm_arbiter_if #(
    parameter int AW = 11
);
    logic          cpu_req;
    logic          cpu_we;
    logic [3:0]    cpu_be;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          int_req;
    logic          cpu_stall;
    logic [31:0]   cpu_rdata;

    logic          dma_req;
    logic          dma_we;
    logic [31:0]   dma_addr;
    logic [31:0]   dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [31:0]   dma_rdata;
    logic          dma_err;

    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, int_req,
        input  cpu_stall, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
        input  mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, int_req,
        output cpu_stall, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata, dma_err,
        output mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/dm_arb_starve.sv
// DMA starvation counter: counts consecutive cycles a DMA request waits
// ungranted, saturating at STARVE_LIMIT, and raises force_dma once reached.
module dm_arb_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt;

    // Wait counter: clears when the request is served or withdrawn, else saturating count.
    always_ff @(posedge clk) begin
        if (reset || !dma_req || dma_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt < LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign force_dma = dma_req && (wait_cnt == LIMIT);

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: CPU MEM stage has fixed priority, a DMA
// requester is forced through after STARVE_LIMIT waiting cycles.
// Optional macro DM_ARBITER_STATS_EN adds stall/grant statistics counters.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 11
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DM_ARBITER_STATS_EN
    output logic [31:0] stat_cpu_stall,
    output logic [31:0] stat_dma_gnt,
`endif
    dm_arbiter_if.slave bus
);

    owner_t        owner;
    logic          cpu_in;
    logic          dma_in;
    logic          force_dma;
    logic          gnt;
    logic          stall;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          rvalid_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          unused_addr_lsbs;

    assign cpu_in = bus.cpu_req && in_range(bus.cpu_addr);
    assign dma_in = in_range(bus.dma_addr);
    assign unused_addr_lsbs = ^{bus.cpu_addr[1:0], bus.dma_addr[1:0]};

    dm_arb_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .dma_req  (bus.dma_req),
        .dma_gnt  (gnt),
        .force_dma(force_dma)
    );

    // Owner selection: in-range CPU first unless the DMA is being forced through.
    always_comb begin
        owner = OWN_NONE;
        if (cpu_in && !force_dma) begin
            owner = OWN_CPU;
        end else if (bus.dma_req) begin
            owner = OWN_DMA;
        end
    end

    // Memory port controls from the owner; idle keeps the CPU address on the port.
    always_comb begin
        we    = 1'b0;
        be    = bus.cpu_be;
        addr  = bus.cpu_addr[AW+1:2];
        wdata = bus.cpu_wdata;
        unique case (owner)
            OWN_CPU: we = bus.cpu_we && !bus.int_req;
            OWN_DMA: begin
                we    = bus.dma_we && dma_in;
                be    = BE_WORD;
                addr  = bus.dma_addr[AW+1:2];
                wdata = bus.dma_wdata;
            end
            default: ;
        endcase
        // Reset cycle must never commit a write.
        if (reset) begin
            we = 1'b0;
        end
    end

    assign gnt   = (owner == OWN_DMA);
    assign stall = force_dma && cpu_in;

    // DMA return path: read data and rvalid/err pulses registered one cycle after grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt && !bus.dma_we && dma_in;
            err_q    <= gnt && !dma_in;
            if (gnt && !bus.dma_we && dma_in) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_stall  = stall;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.dma_gnt    = gnt;
    assign bus.dma_rvalid = rvalid_q;
    assign bus.dma_rdata  = rdata_q;
    assign bus.dma_err    = err_q;
    assign bus.mem_we     = we;
    assign bus.mem_be     = be;
    assign bus.mem_addr   = addr;
    assign bus.mem_wdata  = wdata;

`ifdef DM_ARBITER_STATS_EN
    // Statistics: stall and grant cycle counts, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cpu_stall <= '0;
            stat_dma_gnt   <= '0;
        end else begin
            if (stall) stat_cpu_stall <= stat_cpu_stall + 32'd1;
            if (gnt)   stat_dma_gnt   <= stat_dma_gnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized
// traffic checked against a behavioural model of the arbitration rules.
module tb_dm_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(11)) bus ();

`ifdef DM_ARBITER_STATS_EN
    logic [31:0] stat_cpu_stall;
    logic [31:0] stat_dma_gnt;
`endif

    dm_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .AW          (11)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
`ifdef DM_ARBITER_STATS_EN
        .stat_cpu_stall(stat_cpu_stall),
        .stat_dma_gnt  (stat_dma_gnt),
`endif
        .bus           (bus)
    );

    // Memory array driven by the DUT's port.
    logic [31:0] env_mem [2048];
    assign bus.mem_rdata = env_mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we)
            for (int b = 0; b < 4; b++)
                if (bus.mem_be[b]) env_mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] ref_mem [2048];
    int          ref_wait;
    bit          ref_rvalid, ref_err;
    logic [31:0] ref_rdata;
    logic [31:0] ref_stall_cnt, ref_gnt_cnt;
    // Expected combinational outputs for the current cycle
    int          e_owner;   // 0 idle, 1 cpu, 2 dma
    bit          e_gnt, e_stall, e_we;
    logic [10:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 2048);
    endfunction

    task automatic calc_expect();
        bit cpu_in, forced;
        cpu_in  = bus.cpu_req && (bus.cpu_addr < 32'h2000);
        forced  = bus.dma_req && (ref_wait >= LIMIT);
        e_owner = (cpu_in && !forced) ? 1 : (bus.dma_req ? 2 : 0);
        e_gnt   = (e_owner == 2);
        e_stall = forced && cpu_in;
        e_we    = 1'b0;
        e_be    = bus.cpu_be;
        e_wdata = bus.cpu_wdata;
        e_addr  = 11'(widx(bus.cpu_addr));
        if (e_owner == 1) e_we = bus.cpu_we && !bus.int_req;
        if (e_owner == 2) begin
            e_we    = bus.dma_we && (bus.dma_addr < 32'h2000);
            e_be    = 4'hF;
            e_wdata = bus.dma_wdata;
            e_addr  = 11'(widx(bus.dma_addr));
        end
        if (reset) e_we = 1'b0;
    endtask

    // Advance the model across the rising edge using the inputs held this cycle.
    task automatic model_tick();
        bit dma_in;
        calc_expect();
        dma_in = bus.dma_addr < 32'h2000;
        if (reset) begin
            ref_wait = 0; ref_rvalid = 0; ref_err = 0; ref_rdata = '0;
            ref_stall_cnt = '0; ref_gnt_cnt = '0;
        end else begin
            if (e_owner == 1 && e_we)
                for (int b = 0; b < 4; b++)
                    if (bus.cpu_be[b]) ref_mem[widx(bus.cpu_addr)][8*b +: 8] = bus.cpu_wdata[8*b +: 8];
            ref_rvalid = e_gnt && !bus.dma_we && dma_in;
            ref_err    = e_gnt && !dma_in;
            if (ref_rvalid) ref_rdata = ref_mem[widx(bus.dma_addr)];
            if (e_gnt && bus.dma_we && dma_in) ref_mem[widx(bus.dma_addr)] = bus.dma_wdata;
            if (!bus.dma_req || e_gnt) ref_wait = 0;
            else if (ref_wait < LIMIT) ref_wait = ref_wait + 1;
            if (e_stall) ref_stall_cnt = ref_stall_cnt + 1;
            if (e_gnt)   ref_gnt_cnt   = ref_gnt_cnt + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic set_cpu(input bit req, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wd, input bit irq);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_be = be;
        bus.cpu_addr = addr; bus.cpu_wdata = wd; bus.int_req = irq;
    endtask

    task automatic set_dma(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        bus.dma_req = req; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_cpu(1, 1, 4'hF, 32'h0000_0100, 32'h1234_5678, 0);
        set_dma(0, 0, 0, 0);
        #1;
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        tick();
        tick();
        n_cmp++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid got=%b exp=0", bus.dma_rvalid); end
        n_cmp++; if (bus.dma_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", bus.dma_err); end
        n_cmp++; if (bus.dma_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", bus.dma_rdata); end
        n_cmp++; if (u_dut.u_starve.wait_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_wait got=%0d exp=0", u_dut.u_starve.wait_cnt); end
        n_cmp++; if (env_mem[64] !== ref_mem[64]) begin n_fail++; $display("FAIL rst_nowrite got=%h exp=%h", env_mem[64], ref_mem[64]); end
        reset = 1'b0;
        set_cpu(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_cpu_store_load();
        set_cpu(1, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 0);
        #1;
        n_cmp++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL sw_we got=%b exp=1", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 11'd4) begin n_fail++; $display("FAIL sw_addr got=%0d exp=4", bus.mem_addr); end
        n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL sw_stall got=%b exp=0", bus.cpu_stall); end
        tick();
        set_cpu(1, 0, 4'h0, 32'h0000_0010, 32'h0, 0);
        #1;
        n_cmp++; if (bus.cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data got=%h exp=deadbeef", bus.cpu_rdata); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL lw_we got=%b exp=0", bus.mem_we); end
        tick();
        set_cpu(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_dma_read();
        logic [31:0] word;
        word = $urandom;
        set_dma(1, 1, 32'h0000_0020, word);
        #1;
        n_cmp++; if (bus.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dmaw_gnt got=%b exp=1", bus.dma_gnt); end
        n_cmp++; if (bus.mem_we !== 1'b1 || bus.mem_be !== 4'hF) begin n_fail++; $display("FAIL dmaw_we got=%b/%h exp=1/f", bus.mem_we, bus.mem_be); end
        tick();
        set_dma(1, 0, 32'h0000_0020, 32'h0);
        #1;
        n_cmp++; if (bus.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL dmar_gnt got=%b exp=1", bus.dma_gnt); end
        n_cmp++; if (bus.mem_addr !== 11'd8) begin n_fail++; $display("FAIL dmar_addr got=%0d exp=8", bus.mem_addr); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL dmar_we got=%b exp=0", bus.mem_we); end
        tick();
        set_dma(0, 0, 0, 0);
        n_cmp++; if (bus.dma_rvalid !== 1'b1) begin n_fail++; $display("FAIL dmar_rvalid got=%b exp=1", bus.dma_rvalid); end
        n_cmp++; if (bus.dma_rdata !== word) begin n_fail++; $display("FAIL dmar_rdata got=%h exp=%h", bus.dma_rdata, word); end
        tick();
        n_cmp++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dmar_pulse got=%b exp=0", bus.dma_rvalid); end
    endtask

    task automatic test_int_store();
        logic [31:0] old;
        old = ref_mem[5];
        set_cpu(1, 1, 4'b0100, 32'h0000_0014, $urandom, 1);
        #1;
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL irq_we got=%b exp=0", bus.mem_we); end
        n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_fail++; $display("FAIL irq_stall got=%b exp=0", bus.cpu_stall); end
        n_cmp++; if (bus.dma_gnt !== 1'b0) begin n_fail++; $display("FAIL irq_gnt got=%b exp=0", bus.dma_gnt); end
        tick();
        set_cpu(1, 0, 4'h0, 32'h0000_0014, 32'h0, 0);
        #1;
        n_cmp++; if (bus.cpu_rdata !== old) begin n_fail++; $display("FAIL irq_mem got=%h exp=%h", bus.cpu_rdata, old); end
        tick();
        set_cpu(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_dma_oor();
        logic [31:0] old;
        old = ref_mem[0];
        set_dma(1, 1, 32'h0000_4000, $urandom);
        #1;
        n_cmp++; if (bus.dma_gnt !== 1'b1) begin n_fail++; $display("FAIL oor_gnt got=%b exp=1", bus.dma_gnt); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL oor_we got=%b exp=0", bus.mem_we); end
        tick();
        set_dma(0, 0, 0, 0);
        n_cmp++; if (bus.dma_err !== 1'b1) begin n_fail++; $display("FAIL oor_err got=%b exp=1", bus.dma_err); end
        n_cmp++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL oor_rvalid got=%b exp=0", bus.dma_rvalid); end
        n_cmp++; if (env_mem[0] !== old) begin n_fail++; $display("FAIL oor_mem got=%h exp=%h", env_mem[0], old); end
        tick();
        n_cmp++; if (bus.dma_err !== 1'b0) begin n_fail++; $display("FAIL oor_pulse got=%b exp=0", bus.dma_err); end
    endtask

    // Continuous CPU loads with DMA held: grant every 5th cycle, stall exactly then.
    task automatic test_starve();
        logic [31:0] a;
        bit g;
        set_dma(1, 0, 32'h0000_0040, 32'h0);
        for (int c = 0; c < 15; c++) begin
            a = {19'h0, 11'($urandom), 2'b00};
            set_cpu(1, 0, 4'h0, a, 32'h0, 0);
            g = (c % 5 == 4);
            #1;
            n_cmp++; if (bus.dma_gnt !== g) begin n_fail++; $display("FAIL stv_gnt cyc=%0d got=%b exp=%b", c, bus.dma_gnt, g); end
            n_cmp++; if (bus.cpu_stall !== g) begin n_fail++; $display("FAIL stv_stall cyc=%0d got=%b exp=%b", c, bus.cpu_stall, g); end
            if (!g) begin
                n_cmp++; if (bus.cpu_rdata !== ref_mem[widx(a)]) begin n_fail++; $display("FAIL stv_load cyc=%0d got=%h exp=%h", c, bus.cpu_rdata, ref_mem[widx(a)]); end
            end
            tick();
            n_cmp++; if (bus.dma_rvalid !== g) begin n_fail++; $display("FAIL stv_rvalid cyc=%0d got=%b exp=%b", c, bus.dma_rvalid, g); end
            if (g) begin
                n_cmp++; if (bus.dma_rdata !== ref_mem[16]) begin n_fail++; $display("FAIL stv_rdata cyc=%0d got=%h exp=%h", c, bus.dma_rdata, ref_mem[16]); end
            end
        end
        set_dma(0, 0, 0, 0);
        set_cpu(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        bit g;
        set_dma(1, 0, 32'h0000_0020, 32'h0);
        tick();
        set_dma(0, 0, 0, 0);
        reset = 1'b1;
        set_cpu(1, 1, 4'hF, 32'h0000_0030, 32'hA5A5_A5A5, 0);
        #1;
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rmid_we got=%b exp=0", bus.mem_we); end
        tick();
        reset = 1'b0;
        n_cmp++; if (bus.dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid got=%b exp=0", bus.dma_rvalid); end
        n_cmp++; if (u_dut.u_starve.wait_cnt !== 4'd0) begin n_fail++; $display("FAIL rmid_wait got=%0d exp=0", u_dut.u_starve.wait_cnt); end
`ifdef DM_ARBITER_STATS_EN
        n_cmp++; if (stat_cpu_stall !== 32'h0 || stat_dma_gnt !== 32'h0) begin n_fail++; $display("FAIL rmid_stats got=%0d/%0d exp=0/0", stat_cpu_stall, stat_dma_gnt); end
`endif
        // Build up some DMA waiting, reset, and expect the full wait again afterwards.
        set_cpu(1, 0, 4'h0, 32'h0000_0044, 32'h0, 0);
        set_dma(1, 1, 32'h0000_0048, 32'hC0DE_0001);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            g = (c == 4);
            #1;
            n_cmp++; if (bus.dma_gnt !== g) begin n_fail++; $display("FAIL rmid_regnt cyc=%0d got=%b exp=%b", c, bus.dma_gnt, g); end
            tick();
        end
        set_dma(0, 0, 0, 0);
        set_cpu(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        bit pend = 0;
        int run = 0;
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            logic [31:0] ca;
            ca = {19'h0, 11'($urandom), 2'b00};
            if ($urandom % 8 == 0) ca = ca | 32'h0001_0000;
            set_cpu($urandom % 4 != 0, $urandom % 3 == 0, 4'($urandom), ca, $urandom, $urandom % 6 == 0);
            if (!pend) begin
                logic [31:0] da;
                da = {19'h0, 11'($urandom), 2'b00};
                if ($urandom % 8 == 0) da = da | 32'h0000_2000;
                set_dma($urandom % 3 == 0, $urandom % 2 == 0, da, $urandom);
            end
            #1;
            calc_expect();
            n_cmp++; if (bus.dma_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, bus.dma_gnt, e_gnt); end
            n_cmp++; if (bus.cpu_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, bus.cpu_stall, e_stall); end
            n_cmp++; if (bus.mem_we !== e_we) begin n_fail++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, bus.mem_we, e_we); end
            n_cmp++; if (bus.mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d", c, bus.mem_addr, e_addr); end
            if (e_owner != 0) begin
                n_cmp++; if (bus.mem_be !== e_be) begin n_fail++; $display("FAIL rnd_be cyc=%0d got=%h exp=%h", c, bus.mem_be, e_be); end
            end
            if (e_we) begin
                n_cmp++; if (bus.mem_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, bus.mem_wdata, e_wdata); end
            end
            if (e_owner == 1) begin
                n_cmp++; if (bus.cpu_rdata !== ref_mem[widx(ca)]) begin n_fail++; $display("FAIL rnd_load cyc=%0d got=%h exp=%h", c, bus.cpu_rdata, ref_mem[widx(ca)]); end
            end
            if (bus.dma_req && !e_gnt) run++; else run = 0;
            if (run > LIMIT) bad++;
            pend = bus.dma_req && !e_gnt;
            tick();
            n_cmp++; if (bus.dma_rvalid !== ref_rvalid) begin n_fail++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, bus.dma_rvalid, ref_rvalid); end
            n_cmp++; if (bus.dma_err !== ref_err) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, bus.dma_err, ref_err); end
            if (ref_rvalid) begin
                n_cmp++; if (bus.dma_rdata !== ref_rdata) begin n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, bus.dma_rdata, ref_rdata); end
            end
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL rnd_starve_bound got=%0d exp=0", bad); end
`ifdef DM_ARBITER_STATS_EN
        n_cmp++; if (stat_cpu_stall !== ref_stall_cnt) begin n_fail++; $display("FAIL rnd_stat_stall got=%0d exp=%0d", stat_cpu_stall, ref_stall_cnt); end
        n_cmp++; if (stat_dma_gnt !== ref_gnt_cnt) begin n_fail++; $display("FAIL rnd_stat_gnt got=%0d exp=%0d", stat_dma_gnt, ref_gnt_cnt); end
`endif
        set_cpu(0, 0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_mem_image();
        int diff = 0;
        for (int i = 0; i < 2048; i++) if (env_mem[i] !== ref_mem[i]) diff++;
        n_cmp++; if (diff != 0) begin n_fail++; $display("FAIL mem_image got=%0d differing words exp=0", diff); end
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1;
        set_cpu(0, 0, 0, 0, 0, 0);
        set_dma(0, 0, 0, 0);
        ref_wait = 0; ref_rvalid = 0; ref_err = 0; ref_rdata = '0;
        ref_stall_cnt = '0; ref_gnt_cnt = '0;
        for (int i = 0; i < 2048; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            env_mem[i] <= v;
        end
        @(negedge clk);
        test_reset();
        test_cpu_store_load();
        test_dma_read();
        test_int_store();
        test_dma_oor();
        test_starve();
        test_reset_mid();
        test_random();
        test_mem_image();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shares the single data-memory port (2048 × 32-bit words, byte-enabled writes) between the pipeline's MEM-stage access and a DMA requester. Sits between the MEM stage and the memory array. The CPU gets fixed priority, bounded by a starvation counter that forces a DMA slot. Generates per-cycle memory controls, the CPU stall, and the registered DMA read return.

## Interface
- STARVE_LIMIT, 4: consecutive cycles a DMA request may wait before it is forced through (1..15).
- AW, 11: word-address width into memory (byte address bits [12:2]).
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  MEM stage memory access valid (load or store)
- cpu_we  in  1  store
- cpu_be  in  4  store byte enables, already lane-aligned
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  lane-aligned store data
- int_req  in  1  CP0 interrupt request; suppresses CPU stores
- cpu_stall  out  1  freeze MEM stage and earlier this cycle
- cpu_rdata  out  32  combinational load data
- dma_req  in  1  DMA access valid; held until dma_gnt
- dma_we  in  1  DMA write (always full word)
- dma_addr  in  32  byte address
- dma_wdata  in  32  write data
- dma_gnt  out  1  request accepted this cycle
- dma_rvalid  out  1  dma_rdata valid, one cycle after granted read
- dma_rdata  out  32  registered read data
- dma_err  out  1  one-cycle pulse: granted DMA address out of range
- mem_we  out  1  memory write strobe
- mem_be  out  4  memory byte enables
- mem_addr  out  AW  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational memory read data at mem_addr

## Operation
- In range: addr[31:13]==0. CPU out-of-range accesses never occupy the port, never stall, never write. Bridge/devices handle them.
- Owner per cycle, combinational:
  - CPU if cpu_req in range and not forced.
  - Else DMA if dma_req.
  - Else idle, with mem_we=0 and mem_addr=cpu_addr[12:2].
- Forced: dma_req && wait_cnt==STARVE_LIMIT. DMA owns the port. cpu_stall=1 if CPU in-range cpu_req.
- wait_cnt (4 bit):
  - Increments each cycle dma_req is high and not granted. Saturates at STARVE_LIMIT.
  - Clears on dma_gnt, or when dma_req is low.
- CPU owner:
  - mem_we=cpu_we && !int_req.
  - mem_be=cpu_be.
  - cpu_rdata=mem_rdata.
- DMA owner:
  - dma_gnt=1.
  - mem_we=dma_we && in-range.
  - mem_be=4'b1111.
  - Reads latch mem_rdata into dma_rdata, and dma_rvalid pulses the next cycle.
  - An out-of-range DMA grant writes nothing and pulses dma_err next cycle. dma_rvalid stays 0.
- cpu_rdata=mem_rdata whenever the CPU is not owner. It is meaningless while stalled.

## Timing
- Reset values: wait_cnt=0, dma_rvalid=0, dma_rdata=0, dma_err=0, stats counters=0. Combinational outputs follow inputs.
- CPU access: zero added latency. Loads return in the same cycle. Stores commit on the edge ending the owned cycle.
- DMA: granted cycle N, write commits at edge N, read data valid in cycle N+1.
- Worst-case DMA wait: STARVE_LIMIT cycles under continuous CPU traffic.
- Worst-case CPU stall: 1 cycle per STARVE_LIMIT+1.
- Simultaneous CPU store and int_req: port owned by CPU, no write, no stall.
- Reset asserted mid-transaction: pending dma_rvalid/dma_err are dropped, wait_cnt clears, and no mem_we occurs in the reset cycle.

## Configuration
- DM_ARBITER_STATS_EN defined: adds outputs stat_cpu_stall[31:0] and stat_dma_gnt[31:0].
  - Both count on posedge and wrap modulo 2^32.
  - Both clear on reset.
- Undefined: those ports and counters are absent. Arbitration behaviour is identical either way.

## Structure
- Shared package dm_arb_pkg holds:
  - DM_ADDR_HI=13 (in-range bound bit).
  - Owner encoding enum {OWN_NONE, OWN_CPU, OWN_DMA}.
  - BE_WORD=4'b1111.
- One sub-module, dm_arb_starve, holds the wait_cnt saturating counter and produces the force flag.
- The stats counters live inline under the macro.

## Test plan
- CPU sw to 0x0000_0010 with be 1111, data 0xDEADBEEF, no DMA -> mem_we=1, mem_addr=4, no stall; a following lw returns 0xDEADBEEF in the same cycle.
- CPU in-range load every cycle, dma_req held from cycle 0 -> dma_gnt exactly in cycle 4 (STARVE_LIMIT=4) with cpu_stall=1 only in cycle 4. Repeats every 5 cycles.
- DMA read of 0x0000_0020 with CPU idle -> dma_gnt same cycle; dma_rvalid next cycle with the stored word.
- CPU sb (be 0100) with int_req=1 -> mem_we=0, memory unchanged, cpu_stall=0.
- DMA write to 0x0000_4000 -> dma_gnt=1, mem_we=0, dma_err pulse next cycle.
- Reset asserted the cycle after a DMA read grant -> dma_rvalid=0, wait_cnt=0, and stats counters zero when DM_ARBITER_STATS_EN is defined.
